if_id_queue: RTL

//  Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode.
//  - Decouples IF from ID stalls.
//  - Supports a full flush on redirect, with an optional delay-slot keep mode.
//  - Presents a NOP bubble to ID whenever the queue is empty.

---
 rtl/if_id_queue_pkg.sv | 11 +
 rtl/if_id_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared pipeline constants for the fetch/decode boundary.
package if_id_queue_pkg;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_IF = 1;
    localparam int unsigned STALL_ID = 2;

endpackage

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {pc, inst} between fetch and decode, with redirect flush
// and optional MIPS delay-slot retention; presents a NOP bubble when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_WORD),
    parameter bit                KEEP_DS  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic [PC_W-1:0]            i_pc,
    input  logic [INST_W-1:0]          i_inst,
    output logic                       o_ready,
    input  logic                       o_pop,
    output logic                       o_valid,
    output logic [PC_W-1:0]            o_pc,
    output logic [INST_W-1:0]          o_inst,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CNT_W-1:0] count, cnt_n;
    logic             ds_pending, ds_n;
    logic             full, empty, push, pop, wr_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = i_valid & ~full;
    assign pop   = o_pop & ~empty;

    always_comb begin
        rd_n  = rd_ptr;
        wr_n  = wr_ptr;
        cnt_n = count;
        ds_n  = ds_pending;
        wr_en = 1'b0;
        if (flush) begin
            if (!KEEP_DS) begin
                rd_n  = '0;
                wr_n  = '0;
                cnt_n = '0;
                ds_n  = 1'b0;
            end else if (count >= CNT_W'(2)) begin
                // Head is the branch; the next entry survives as the delay slot.
                rd_n  = rd_ptr + PTR_W'(1);
                wr_n  = rd_ptr + PTR_W'(2);
                cnt_n = CNT_W'(1);
                ds_n  = 1'b0;
            end else if (count == CNT_W'(1)) begin
                rd_n = rd_ptr + PTR_W'(1);
                if (push) begin
                    wr_en = 1'b1;
                    wr_n  = wr_ptr + PTR_W'(1);
                    cnt_n = CNT_W'(1);
                    ds_n  = 1'b0;
                end else begin
                    cnt_n = '0;
                    ds_n  = 1'b1;
                end
            end else begin
                cnt_n = '0;
                ds_n  = 1'b1;
            end
        end else begin
            wr_en = push;
            if (push) begin
                wr_n = wr_ptr + PTR_W'(1);
                ds_n = 1'b0;
            end
            if (pop) begin
                rd_n = rd_ptr + PTR_W'(1);
            end
            cnt_n = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            count      <= cnt_n;
            ds_pending <= ds_n;
            if (wr_en) begin
                pc_mem[wr_ptr]   <= i_pc;
                inst_mem[wr_ptr] <= i_inst;
            end
        end
    end

    assign o_ready = ~full;
    assign o_valid = ~empty;
    assign o_count = count;
    assign o_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign o_inst  = empty ? NOP_INST : inst_mem[rd_ptr];

endmodule
